// File: rtl/fetch_prefetch_ctrl_pkg.sv
// Shared fetch-path sizing so the IF stage and the hazard unit agree on widths,
// memory span, prefetch depth and the boot address.
package fetch_prefetch_ctrl_pkg;
   localparam int ADDRESS_LEN  = 8;
   localparam int WORD_LEN     = 32;
   localparam int MEMORY_SIZE  = 24;
   localparam int FETCH_QDEPTH = 4;
   localparam int RESET_PC     = 0;

   typedef struct packed {
      logic [WORD_LEN-1:0]    word;
      logic [ADDRESS_LEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [ADDRESS_LEN-1:0] pc_inc(input logic [ADDRESS_LEN-1:0] pc);
      return (pc == ADDRESS_LEN'(MEMORY_SIZE - 1)) ? '0 : pc + ADDRESS_LEN'(1);
   endfunction
endpackage

// File: rtl/fetch_prefetch_ctrl_prefetch_fifo.sv
// Synchronous prefetch queue: head visible combinationally, zero-latency read;
// push while full is only legal together with a pop, flush empties in one edge.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] rdata
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// IF-stage sequencer: one word fetched per cycle into the prefetch queue, head seen one edge later;
// decode stalls via inst_ready, a full queue freezes fetch_pc, redirect flushes with a one-cycle bubble.
module fetch_prefetch_ctrl
   import fetch_prefetch_ctrl_pkg::*;
#(
   parameter int DEPTH    = FETCH_QDEPTH,
   parameter int RESET_PC = fetch_prefetch_ctrl_pkg::RESET_PC
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDRESS_LEN-1:0] imem_adr,
   input  logic [WORD_LEN-1:0]    imem_inst,
   input  logic                   redirect_valid,
   input  logic [ADDRESS_LEN-1:0] redirect_pc,
   output logic                   inst_valid,
   output logic [WORD_LEN-1:0]    inst,
   output logic [ADDRESS_LEN-1:0] inst_pc,
   input  logic                   inst_ready
);
   logic [ADDRESS_LEN-1:0] fetch_pc;
   logic                   push, pop, full, empty;
   fetch_entry_t           wr_entry, head;

   assign pop      = !empty && inst_ready;
   assign push     = !redirect_valid && (!full || pop);
   assign wr_entry = '{word: imem_inst, pc: fetch_pc};

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wr_entry),
      .full  (full),
      .empty (empty),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (rst)
         fetch_pc <= ADDRESS_LEN'(RESET_PC);
      else if (redirect_valid)
         fetch_pc <= ADDRESS_LEN'(redirect_pc % MEMORY_SIZE);
      else if (push)
         fetch_pc <= pc_inc(fetch_pc);
   end

   assign imem_adr   = fetch_pc;
   assign inst_valid = !empty;
   assign inst       = empty ? '0 : head.word;
   assign inst_pc    = empty ? '0 : head.pc;
endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Bench for fetch_prefetch_ctrl: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the fetch rules.
module tb_fetch_prefetch_ctrl;
   import fetch_prefetch_ctrl_pkg::*;

   localparam int QD = 4;
   localparam int EW = WORD_LEN + ADDRESS_LEN;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [ADDRESS_LEN-1:0] imem_adr;
   logic [WORD_LEN-1:0]    imem_inst;
   logic                   redirect_valid;
   logic [ADDRESS_LEN-1:0] redirect_pc;
   logic                   inst_valid;
   logic [WORD_LEN-1:0]    inst;
   logic [ADDRESS_LEN-1:0] inst_pc;
   logic                   inst_ready;

   logic [WORD_LEN-1:0] imem [MEMORY_SIZE];
   assign imem_inst = (int'(imem_adr) < MEMORY_SIZE) ? imem[imem_adr] : 32'hDEAD_BEEF;

   fetch_prefetch_ctrl #(.DEPTH(QD), .RESET_PC(0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_adr       (imem_adr),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: list of {word, pc} in arrival order plus the next fetch address.
   logic [EW-1:0] mq[$];
   int            mpc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit popped;
      if (rst) begin
         mq.delete();
         mpc = 0;
      end else begin
         popped = (mq.size() != 0) && inst_ready;
         if (redirect_valid) begin
            mq.delete();
            mpc = int'(redirect_pc) % MEMORY_SIZE;
         end else begin
            if (popped) void'(mq.pop_front());
            if (mq.size() < QD) begin
               mq.push_back({imem[mpc], ADDRESS_LEN'(mpc)});
               mpc = (mpc + 1) % MEMORY_SIZE;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [EW-1:0] h;
      h = (mq.size() != 0) ? mq[0] : '0;
      check("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
      check("inst", 64'(inst), 64'(h[EW-1:ADDRESS_LEN]));
      check("inst_pc", 64'(inst_pc), 64'(h[ADDRESS_LEN-1:0]));
      check("imem_adr", 64'(imem_adr), 64'(mpc));
   endtask

   task automatic cycle(input logic r, input logic rv, input logic [ADDRESS_LEN-1:0] rpc,
                        input logic rdy);
      rst = r; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      for (int i = 0; i < MEMORY_SIZE; i++) imem[i] = $urandom;
      mpc = 0;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      @(negedge clk);

      // Reset, then free run
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      check("rst_valid", 64'(inst_valid), 64'd0);
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_adr", 64'(imem_adr), 64'd0);
      cycle(0, 0, 0, 1);
      check("first_pc", 64'(inst_pc), 64'd0);
      check("first_inst", 64'(inst), 64'(imem[0]));
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, 0, 1);
         check("run_pc", 64'(inst_pc), 64'(i));
      end

      // Stall fill from reset, then release
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
      check("stall_adr", 64'(imem_adr), 64'd4);
      check("stall_pc", 64'(inst_pc), 64'd0);
      for (int i = 1; i <= 5; i++) begin
         cycle(0, 0, 0, 1);
         check("drain_pc", 64'(inst_pc), 64'(i));
         check("drain_valid", 64'(inst_valid), 64'd1);
      end

      // Redirect with full queue
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 11, 0);
      check("redir_valid", 64'(inst_valid), 64'd0);
      check("redir_adr", 64'(imem_adr), 64'd11);
      cycle(0, 0, 0, 0);
      check("redir_pc", 64'(inst_pc), 64'd11);
      check("redir_inst", 64'(inst), 64'(imem[11]));

      // Wraparound at end of memory
      cycle(0, 1, ADDRESS_LEN'(MEMORY_SIZE - 1), 1);
      cycle(0, 0, 0, 1);
      check("wrap_last", 64'(inst_pc), 64'(MEMORY_SIZE - 1));
      cycle(0, 0, 0, 1);
      check("wrap_zero", 64'(inst_pc), 64'd0);

      // Out-of-range redirect target folds into memory
      cycle(0, 1, 8'd200, 1);
      check("clamp_adr", 64'(imem_adr), 64'(200 % MEMORY_SIZE));

      // Redirect coinciding with pop and non-full queue
      cycle(0, 0, 0, 1);
      cycle(0, 1, 5, 1);
      check("rwin_valid", 64'(inst_valid), 64'd0);
      cycle(0, 0, 0, 1);
      check("rwin_pc", 64'(inst_pc), 64'd5);
      cycle(0, 0, 0, 1);
      check("rwin_next", 64'(inst_pc), 64'd6);

      // Reset while three entries are queued
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check("pre_rst_valid", 64'(inst_valid), 64'd1);
      cycle(1, 0, 0, 0);
      check("mid_rst_valid", 64'(inst_valid), 64'd0);
      check("mid_rst_inst", 64'(inst), 64'd0);
      check("mid_rst_pc", 64'(inst_pc), 64'd0);
      check("mid_rst_adr", 64'(imem_adr), 64'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 79) == 0),
               ($urandom_range(0, 9) == 0),
               ADDRESS_LEN'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < 65));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
